apb_rr_arbiter: RTL and testbench
=================================

// Module: apb_rr_arbiter
// PURPOSE
//  Shares one peripheral resource (e.g. a DMA channel or a shared bus port) among NUM_REQ
//  requesters using round-robin arbitration with a per-requester enable mask.
//  An APB slave port configures the block. Software programs the enable and mask bits and
//  reads the current owner. Sits beside the interrupt controller on the same APB segment.
// PARAMETERS
//  NUM_REQ   8               number of requesters (2..8)
//  REQ_W     $clog2(NUM_REQ) requester index width
//  MAX_HOLD  16              max grant length in cycles (used only with ARB_TIMEOUT_EN)
// PORTS
//  pclk_i       in   1        clock
//  prst_n_i     in   1        reset, asynchronous, active-low
//  psel_i       in   1        APB select
//  penable_i    in   1        APB enable
//  pwrite_i     in   1        APB write=1 / read=0
//  paddr_i      in   2        APB register address
//  pwdata_i     in   8        APB write data
//  pready_o     out  1        APB ready
//  prdata_o     out  8        APB read data
//  req_i        in   NUM_REQ  request per requester, held high until served
//  done_i       in   1        single-cycle pulse from the current owner releasing the resource
//  gnt_o        out  NUM_REQ  one-hot grant, registered
//  gnt_valid_o  out  1        high while a grant is held (equals |gnt_o)
//  gnt_id_o     out  REQ_W    index of the current/last owner
// BEHAVIOUR
//  Reset (async, prst_n_i=0)
//   - All outputs go to 0 immediately: gnt_o, gnt_valid_o, gnt_id_o, pready_o, prdata_o.
//   - CTRL=0x01, MASK=all ones, last=NUM_REQ-1, state=S_IDLE, timeout flag=0.
//  APB interface
//   - No wait states: pready_o = psel_i & penable_i.
//   - Writes commit on the clock edge that ends the access phase.
//   - Reads: prdata_o is driven during the access phase, 0 otherwise.
//   - Unmapped bits read as 0. Writes to read-only fields are ignored.
//  Register map
//   - 0 CTRL   [0] arb_en (R/W)
//   - 1 MASK   [NUM_REQ-1:0] per-requester enable (R/W)
//   - 2 STATUS [7] busy (RO), [6] timeout (W1C), [REQ_W-1:0] gnt_id (RO)
//   - 3 REQ    [NUM_REQ-1:0] raw req_i snapshot (RO)
//  State machine and arbitration
//   - States: S_IDLE, S_GRANT, S_RELEASE.
//   - Eligible set: elig = req_i & MASK, considered only when arb_en=1.
//   - Winner: first set bit of elig, searching from (last+1) mod NUM_REQ upward, wrapping.
//   - S_IDLE:
//     - If elig is nonzero, go to S_GRANT.
//     - gnt_o = one-hot(winner) from the next edge, i.e. 1-cycle latency from req.
//     - gnt_id_o and last are loaded with the winner.
//   - S_GRANT: gnt_o holds until done_i=1 OR req_i[owner]=0. Either event goes to S_RELEASE,
//     and gnt_o=0 after that edge.
//   - S_RELEASE (exactly 1 dead cycle, gnt_o=0):
//     - Re-arbitrate. If elig is nonzero, go to S_GRANT; else go to S_IDLE.
//     - The owner that just released has the lowest priority on this pass.
//  Boundary conditions
//   - done_i in S_IDLE or S_RELEASE is ignored.
//   - MASK or arb_en change during S_GRANT does not affect the current owner; it applies at
//     the next arbitration.
//   - A requester dropping req_i before it is granted is simply skipped.
//   - Wrap: with last=NUM_REQ-1 the search starts at index 0.
//   - Async reset mid-grant drops gnt_o in the same cycle. No release cycle follows.
//   - An APB write to the same register on the same edge as a hardware update: the
//     timeout-set wins over the W1C clear.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined
//   - Hold counter (width $clog2(MAX_HOLD+1)) clears on entry to S_GRANT and counts each
//     cycle in S_GRANT.
//   - When it reaches MAX_HOLD with no release: forced go to S_RELEASE, gnt_o drops, and
//     STATUS[6] is set (sticky until W1C).
//  ARB_TIMEOUT_EN undefined
//   - No counter is built; a grant is held indefinitely.
//   - STATUS[6] reads 0 and writes to it are ignored.
// TESTING
//  1. Reset release, req_i=0x05 -> after 1 edge gnt_o=0x01, gnt_id_o=0. Pulse done_i ->
//     1 dead cycle, then gnt_o=0x04, gnt_id_o=2.
//  2. req_i=0xFF held, done_i pulsed 2 cycles after each grant -> grant order
//     0,1,2,...,7,0,1. gnt_o never has more than 1 bit set.
//  3. APB write MASK=0xFE, req_i=0x03 -> only gnt_o=0x02 is ever granted. Write CTRL=0
//     -> no grants. Write CTRL=1 -> grants resume.
//  4. Owner 3 granted, APB read addr 2 -> prdata_o=0x83, pready_o=1 in the access phase.
//     After release, the same read -> 0x03.
//  5. (ARB_TIMEOUT_EN, MAX_HOLD=16) req_i=0x10 held, no done_i -> gnt_o falls after 16
//     grant cycles, STATUS=0xC4 then 0x44. Write 0x40 to addr 2 -> STATUS[6]=0.
//  6. Drive prst_n_i=0 mid-grant, between clock edges -> gnt_o=0 immediately. After
//     release, reads give CTRL=0x01, MASK=0xFF.

Source files
------------

// File: rtl/apb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// apb_rr_arbiter
//   Round-robin arbiter that shares one resource among NUM_REQ requesters.
//   Each requester has an enable bit in MASK, and a global enable sits in CTRL.
//   The arbiter grants one requester at a time. It holds that grant until the
//   owner pulses done_i or drops its request. After every grant it inserts
//   exactly one dead cycle before granting again. The owner that just released
//   gets the lowest priority on the next search.
//
//   Optional feature macro: ARB_TIMEOUT_EN
//     When defined, a hold counter forces a release after MAX_HOLD grant
//     cycles and sets the sticky STATUS[6] timeout flag, which is cleared by
//     writing 1 to it. When undefined, no counter is built and a grant is held
//     indefinitely.
//
// Ports
//   pclk_i, prst_n_i    clock, asynchronous active-low reset
//   psel_i, penable_i   APB select / enable (no wait states)
//   pwrite_i, paddr_i   APB direction / register address (2 bits)
//   pwdata_i, prdata_o  APB write / read data (8 bits)
//   pready_o            APB ready (psel_i & penable_i)
//   req_i               per-requester request, held until served
//   done_i              release pulse from the current owner
//   gnt_o               registered one-hot grant
//   gnt_valid_o         |gnt_o
//   gnt_id_o            index of the current / last owner
//
// Register map
//   0 CTRL    [0] arb_en
//   1 MASK    [NUM_REQ-1:0] requester enables
//   2 STATUS  [7] busy, [6] timeout (W1C), [REQ_W-1:0] gnt_id
//   3 REQ     [NUM_REQ-1:0] raw req_i
// -----------------------------------------------------------------------------
module apb_rr_arbiter #(
  parameter int NUM_REQ  = 8,
  parameter int REQ_W    = $clog2(NUM_REQ),
  parameter int MAX_HOLD = 16
) (
  input  logic               pclk_i,
  input  logic               prst_n_i,
  input  logic               psel_i,
  input  logic               penable_i,
  input  logic               pwrite_i,
  input  logic [1:0]         paddr_i,
  input  logic [7:0]         pwdata_i,
  output logic               pready_o,
  output logic [7:0]         prdata_o,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               done_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               gnt_valid_o,
  output logic [REQ_W-1:0]   gnt_id_o
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_HOLD < 1) begin : g_bad_params
    $error("apb_rr_arbiter: NUM_REQ must be 2..8 and MAX_HOLD must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;

  state_t             state_q;
  logic               arb_en_q;
  logic [NUM_REQ-1:0] mask_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [REQ_W-1:0]   gnt_id_q;
  logic [REQ_W-1:0]   last_q;
  logic               timeout_flag;

  logic               apb_access;
  logic               apb_wr;
  logic               apb_rd;
  logic [NUM_REQ-1:0] elig;
  logic               win_found;
  logic [REQ_W-1:0]   win_id;
  logic [REQ_W-1:0]   scan_idx;
  logic [7:0]         rdata;

  assign apb_access = psel_i & penable_i;
  assign apb_wr     = apb_access & pwrite_i;
  assign apb_rd     = apb_access & ~pwrite_i;

  assign elig = arb_en_q ? (req_i & mask_q) : '0;

  // The search starts one past the last owner and wraps, so the previous owner
  // is examined last.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = last_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = (scan_idx == REQ_W'(NUM_REQ - 1)) ? '0 : scan_idx + REQ_W'(1);
      if (!win_found && elig[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  logic [CNT_W-1:0] hold_cnt_q;
  logic [CNT_W-1:0] hold_cnt_d;
  logic             hold_expired;
  logic             timeout_q;

  assign hold_cnt_d   = hold_cnt_q + CNT_W'(1);
  assign hold_expired = (hold_cnt_d == CNT_W'(MAX_HOLD));
  assign timeout_flag = timeout_q;
`else
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      last_q   <= REQ_W'(NUM_REQ - 1);
      arb_en_q <= 1'b1;
      mask_q   <= '1;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      if (apb_wr && paddr_i == ADDR_CTRL) arb_en_q <= pwdata_i[0];
      if (apb_wr && paddr_i == ADDR_MASK) mask_q   <= pwdata_i[NUM_REQ-1:0];
`ifdef ARB_TIMEOUT_EN
      // The clear comes first, so a timeout on the same edge overrides it below.
      if (apb_wr && paddr_i == ADDR_STATUS && pwdata_i[6]) timeout_q <= 1'b0;
`endif

      case (state_q)
        S_IDLE, S_RELEASE: begin
          if (win_found) begin
            state_q  <= S_GRANT;
            gnt_q    <= NUM_REQ'(1) << win_id;
            gnt_id_q <= win_id;
            last_q   <= win_id;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
`endif
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_GRANT: begin
          if (done_i || !req_i[gnt_id_q]) begin
            state_q <= S_RELEASE;
            gnt_q   <= '0;
          end
`ifdef ARB_TIMEOUT_EN
          else if (hold_expired) begin
            state_q   <= S_RELEASE;
            gnt_q     <= '0;
            timeout_q <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_d;
          end
`endif
        end

        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (apb_rd && prst_n_i) begin
      case (paddr_i)
        ADDR_CTRL:   rdata[0] = arb_en_q;
        ADDR_MASK:   rdata[NUM_REQ-1:0] = mask_q;
        ADDR_STATUS: begin
          rdata[7]         = (state_q == S_GRANT);
          rdata[6]         = timeout_flag;
          rdata[REQ_W-1:0] = gnt_id_q;
        end
        default:     rdata[NUM_REQ-1:0] = req_i;
      endcase
    end
  end

  // Gating with the reset makes the APB outputs drop at once when reset is asserted.
  assign pready_o    = apb_access & prst_n_i;
  assign prdata_o    = rdata;
  assign gnt_o       = gnt_q;
  assign gnt_valid_o = |gnt_q;
  assign gnt_id_o    = gnt_id_q;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
module tb_apb_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [1:0] paddr;
  logic [7:0] pwdata;
  logic       pready;
  logic [7:0] prdata;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_id;

  int checks = 0;
  int passes = 0;

  apb_rr_arbiter #(.NUM_REQ(8), .MAX_HOLD(16)) dut (
    .pclk_i     (clk),
    .prst_n_i   (rst_n),
    .psel_i     (psel),
    .penable_i  (penable),
    .pwrite_i   (pwrite),
    .paddr_i    (paddr),
    .pwdata_i   (pwdata),
    .pready_o   (pready),
    .prdata_o   (prdata),
    .req_i      (req),
    .done_i     (done),
    .gnt_o      (gnt),
    .gnt_valid_o(gnt_valid),
    .gnt_id_o   (gnt_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    req = 0; done = 0;
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic apb_write(input logic [1:0] a, input logic [7:0] d);
    psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
    tick();
    penable = 1;
    tick();
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic apb_read(input logic [1:0] a, output logic [7:0] d,
                          output logic rdy_setup, output logic rdy_acc);
    psel = 1; penable = 0; pwrite = 0; paddr = a;
    #1;
    rdy_setup = pready;
    tick();
    penable = 1;
    #1;
    d       = prdata;
    rdy_acc = pready;
    tick();
    psel = 0; penable = 0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic rs, ra;
    rst_n = 0; psel = 1; penable = 1; pwrite = 0; paddr = 2; pwdata = 0;
    req = 8'hFF; done = 0;
    #3;
    checks++; if (gnt !== 8'h00) $display("FAIL rst_gnt got=%h exp=00", gnt); else passes++;
    checks++; if (gnt_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", gnt_valid); else passes++;
    checks++; if (gnt_id !== 3'd0) $display("FAIL rst_id got=%0d exp=0", gnt_id); else passes++;
    checks++; if (pready !== 1'b0) $display("FAIL rst_pready got=%b exp=0", pready); else passes++;
    checks++; if (prdata !== 8'h00) $display("FAIL rst_prdata got=%h exp=00", prdata); else passes++;
    psel = 0; penable = 0; req = 0;
    tick();
    rst_n = 1;
    apb_read(2'd0, d, rs, ra);
    checks++; if (d !== 8'h01) $display("FAIL rst_ctrl got=%h exp=01", d); else passes++;
    checks++; if (rs !== 1'b0) $display("FAIL rst_pready_setup got=%b exp=0", rs); else passes++;
    checks++; if (ra !== 1'b1) $display("FAIL rst_pready_access got=%b exp=1", ra); else passes++;
    apb_read(2'd1, d, rs, ra);
    checks++; if (d !== 8'hFF) $display("FAIL rst_mask got=%h exp=FF", d); else passes++;
    apb_read(2'd2, d, rs, ra);
    checks++; if (d !== 8'h00) $display("FAIL rst_status got=%h exp=00", d); else passes++;
    checks++; if (prdata !== 8'h00) $display("FAIL idle_prdata got=%h exp=00", prdata); else passes++;
  endtask

  task automatic test_basic();
    do_reset();
    req = 8'h05;
    tick();
    checks++; if (gnt !== 8'h01) $display("FAIL basic_gnt0 got=%h exp=01", gnt); else passes++;
    checks++; if (gnt_id !== 3'd0) $display("FAIL basic_id0 got=%0d exp=0", gnt_id); else passes++;
    checks++; if (gnt_valid !== 1'b1) $display("FAIL basic_valid got=%b exp=1", gnt_valid); else passes++;
    done = 1;
    tick();
    done = 0;
    checks++; if (gnt !== 8'h00) $display("FAIL basic_dead got=%h exp=00", gnt); else passes++;
    checks++; if (gnt_valid !== 1'b0) $display("FAIL basic_dead_valid got=%b exp=0", gnt_valid); else passes++;
    tick();
    checks++; if (gnt !== 8'h04) $display("FAIL basic_gnt2 got=%h exp=04", gnt); else passes++;
    checks++; if (gnt_id !== 3'd2) $display("FAIL basic_id2 got=%0d exp=2", gnt_id); else passes++;
    req = 8'h00;
    tick();
    checks++; if (gnt !== 8'h00) $display("FAIL basic_reqdrop got=%h exp=00", gnt); else passes++;
    tick();
    done = 1;
    tick();
    done = 0;
    checks++; if (gnt_id !== 3'd2) $display("FAIL basic_id_hold got=%0d exp=2", gnt_id); else passes++;
    req = 8'h01;
    tick();
    checks++; if (gnt !== 8'h01) $display("FAIL basic_wrap got=%h exp=01", gnt); else passes++;
    req = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    logic [7:0] e;
    do_reset();
    req = 8'hFF;
    tick();
    for (int k = 0; k < 10; k++) begin
      e = 8'h01 << (k % 8);
      checks++; if (gnt !== e) $display("FAIL rr_gnt k=%0d got=%h exp=%h", k, gnt, e); else passes++;
      checks++; if (gnt_id !== 3'(k % 8)) $display("FAIL rr_id k=%0d got=%0d exp=%0d", k, gnt_id, k % 8); else passes++;
      tick();
      checks++; if ($countones(gnt) > 1 || gnt !== e) $display("FAIL rr_hold k=%0d got=%h exp=%h", k, gnt, e); else passes++;
      done = 1;
      tick();
      done = 0;
      checks++; if (gnt !== 8'h00) $display("FAIL rr_dead k=%0d got=%h exp=00", k, gnt); else passes++;
      tick();
    end
    req = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_mask();
    do_reset();
    apb_write(2'd1, 8'hFE);
    req = 8'h03;
    tick();
    checks++; if (gnt !== 8'h02) $display("FAIL mask_gnt got=%h exp=02", gnt); else passes++;
    done = 1;
    tick();
    done = 0;
    checks++; if (gnt !== 8'h00) $display("FAIL mask_dead got=%h exp=00", gnt); else passes++;
    tick();
    checks++; if (gnt !== 8'h02) $display("FAIL mask_regnt got=%h exp=02", gnt); else passes++;
    apb_write(2'd0, 8'h00);
    checks++; if (gnt !== 8'h02) $display("FAIL mask_ctrl_off_keeps got=%h exp=02", gnt); else passes++;
    done = 1;
    tick();
    done = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (gnt !== 8'h00) $display("FAIL mask_disabled k=%0d got=%h exp=00", k, gnt); else passes++;
    end
    apb_write(2'd0, 8'h01);
    checks++; if (gnt !== 8'h00) $display("FAIL mask_enable_edge got=%h exp=00", gnt); else passes++;
    tick();
    checks++; if (gnt !== 8'h02) $display("FAIL mask_resume got=%h exp=02", gnt); else passes++;
    req = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_status();
    logic [7:0] d;
    logic rs, ra;
    do_reset();
    req = 8'h08;
    tick();
    checks++; if (gnt !== 8'h08) $display("FAIL st_gnt got=%h exp=08", gnt); else passes++;
    apb_read(2'd2, d, rs, ra);
    checks++; if (d !== 8'h83) $display("FAIL st_busy got=%h exp=83", d); else passes++;
    checks++; if (ra !== 1'b1) $display("FAIL st_pready got=%b exp=1", ra); else passes++;
    checks++; if (rs !== 1'b0) $display("FAIL st_pready_setup got=%b exp=0", rs); else passes++;
    req = 8'h00;
    tick();
    tick();
    apb_read(2'd2, d, rs, ra);
    checks++; if (d !== 8'h03) $display("FAIL st_idle got=%h exp=03", d); else passes++;
    req = 8'h5A;
    apb_read(2'd3, d, rs, ra);
    checks++; if (d !== 8'h5A) $display("FAIL st_req got=%h exp=5A", d); else passes++;
    req = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_skip();
    do_reset();
    req = 8'h06;
    tick();
    checks++; if (gnt !== 8'h02) $display("FAIL skip_gnt1 got=%h exp=02", gnt); else passes++;
    req = 8'h02;
    done = 1;
    tick();
    done = 0;
    checks++; if (gnt !== 8'h00) $display("FAIL skip_dead got=%h exp=00", gnt); else passes++;
    tick();
    checks++; if (gnt !== 8'h02) $display("FAIL skip_regnt got=%h exp=02", gnt); else passes++;
    checks++; if (gnt_id !== 3'd1) $display("FAIL skip_id got=%0d exp=1", gnt_id); else passes++;
    req = 8'h00;
    tick();
    tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_hold();
    logic [7:0] d;
    logic rs, ra;
    do_reset();
    req = 8'h10;
    tick();
    checks++; if (gnt !== 8'h10) $display("FAIL to_gnt got=%h exp=10", gnt); else passes++;
    repeat (15) tick();
    checks++; if (gnt !== 8'h10) $display("FAIL to_hold15 got=%h exp=10", gnt); else passes++;
    tick();
    checks++; if (gnt !== 8'h00) $display("FAIL to_drop got=%h exp=00", gnt); else passes++;
    apb_read(2'd2, d, rs, ra);
    checks++; if (d !== 8'hC4) $display("FAIL to_status_busy got=%h exp=C4", d); else passes++;
    req = 8'h00;
    tick();
    tick();
    apb_read(2'd2, d, rs, ra);
    checks++; if (d !== 8'h44) $display("FAIL to_status_idle got=%h exp=44", d); else passes++;
    apb_write(2'd2, 8'h40);
    apb_read(2'd2, d, rs, ra);
    checks++; if (d !== 8'h04) $display("FAIL to_w1c got=%h exp=04", d); else passes++;
  endtask
`else
  task automatic test_hold();
    logic [7:0] d;
    logic rs, ra;
    do_reset();
    req = 8'h10;
    tick();
    checks++; if (gnt !== 8'h10) $display("FAIL hold_gnt got=%h exp=10", gnt); else passes++;
    repeat (40) tick();
    checks++; if (gnt !== 8'h10) $display("FAIL hold_forever got=%h exp=10", gnt); else passes++;
    apb_write(2'd2, 8'h40);
    apb_read(2'd2, d, rs, ra);
    checks++; if (d !== 8'h84) $display("FAIL hold_status got=%h exp=84", d); else passes++;
    req = 8'h00;
    tick();
    tick();
  endtask
`endif

  task automatic test_reset_mid_grant();
    logic [7:0] d;
    logic rs, ra;
    do_reset();
    apb_write(2'd1, 8'h0F);
    apb_write(2'd0, 8'h01);
    req = 8'h02;
    tick();
    checks++; if (gnt !== 8'h02) $display("FAIL mrst_gnt got=%h exp=02", gnt); else passes++;
    #2;
    rst_n = 0;
    #1;
    checks++; if (gnt !== 8'h00) $display("FAIL mrst_gnt_drop got=%h exp=00", gnt); else passes++;
    checks++; if (gnt_valid !== 1'b0) $display("FAIL mrst_valid got=%b exp=0", gnt_valid); else passes++;
    checks++; if (gnt_id !== 3'd0) $display("FAIL mrst_id got=%0d exp=0", gnt_id); else passes++;
    req = 8'h00;
    tick();
    rst_n = 1;
    apb_read(2'd0, d, rs, ra);
    checks++; if (d !== 8'h01) $display("FAIL mrst_ctrl got=%h exp=01", d); else passes++;
    apb_read(2'd1, d, rs, ra);
    checks++; if (d !== 8'hFF) $display("FAIL mrst_mask got=%h exp=FF", d); else passes++;
    checks++; if (gnt !== 8'h00) $display("FAIL mrst_no_gnt got=%h exp=00", gnt); else passes++;
    req = 8'h02;
    tick();
    checks++; if (gnt !== 8'h02) $display("FAIL mrst_regnt got=%h exp=02", gnt); else passes++;
    req = 8'h00;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_mask();
    test_status();
    test_skip();
    test_hold();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
